// File: rtl/spi_cmd_slave_if.sv
// spi_cmd_slave_if: SPI pin bundle between the MCU master and the command slave
interface spi_cmd_slave_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    modport master (output spi_sclk, spi_cs_n, spi_mosi, input spi_miso);
    modport slave (input spi_sclk, spi_cs_n, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI mode-0 slave that decodes 7-byte frames into DDS control registers
module spi_cmd_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int PIC_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_cmd_slave_if.slave        spi,
    output logic [7:0]            pic_dat,
    output logic [23:0]           fre_dat,
    output logic [15:0]           amp_dat,
    output logic                  SPI_OK,
    output logic                  frame_ok,
    output logic                  frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    localparam logic [7:0] PIC_MAX_B = PIC_MAX[7:0];
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, start;
    logic [55:0] shift_q;
    logic [5:0] bit_cnt;
    logic [7:0] tx_q, csum;
    logic accept;
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise = cs_s & ~cs_d;
    assign cs_fall = ~cs_s & cs_d;
    assign start = (state != SHIFT) && cs_fall;
    assign csum = shift_q[55:48] ^ shift_q[47:40] ^ shift_q[39:32] ^ shift_q[31:24]
                ^ shift_q[23:16] ^ shift_q[15:8] ^ shift_q[7:0];
    assign accept = (bit_cnt == 6'd56) && (csum == 8'h00) && (shift_q[55:48] != 8'h00)
                 && (shift_q[55:48] <= PIC_MAX_B);
    assign spi.spi_miso = tx_q[7];
    // Bring the asynchronous SPI pins into the clk domain; cs_n idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync <= '1;
            mosi_sync <= '0;
            sclk_d <= 1'b0;
            cs_d <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            sclk_d <= sclk_s;
            cs_d <= cs_s;
        end
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Next state: a cs_n fall seen in CHECK goes straight back into SHIFT
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE)  ? (cs_fall ? SHIFT : IDLE) :
                   (state == SHIFT) ? (cs_rise ? CHECK : SHIFT) :
                                      (cs_fall ? SHIFT : IDLE);
    end
    // Receive shifter, saturating bit counter and MISO echo byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
            tx_q <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            tx_q <= 8'h5A;
        end else if (state != SHIFT) begin
            tx_q <= '0;
        end else if (sclk_rise && !cs_rise) begin
            shift_q <= {shift_q[54:0], mosi_s};
            bit_cnt <= (bit_cnt == 6'd57) ? bit_cnt : bit_cnt + 6'd1;
        end else if (sclk_fall) begin
            tx_q <= (bit_cnt == 6'd0)        ? tx_q :
                    (bit_cnt[2:0] != 3'd0)   ? {tx_q[6:0], 1'b0} :
                    (bit_cnt >= 6'd56)       ? 8'h00 : shift_q[7:0];
        end
    end
    // Commit a checked frame to the DDS registers in one edge, or flag the rejection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pic_dat <= '0;
            fre_dat <= '0;
            amp_dat <= '0;
            SPI_OK <= 1'b0;
            frame_ok <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok <= (state == CHECK) && accept;
            frame_err <= (state == CHECK) && !accept;
            if ((state == CHECK) && accept) begin
                pic_dat <= shift_q[55:48];
                fre_dat <= shift_q[47:24];
                amp_dat <= shift_q[23:8];
                SPI_OK <= 1'b1;
            end
        end
    end
endmodule
